irq_ctl: RTL and testbench

Memory-mapped interrupt controller sitting directly upstream of the 65C02 core. It collects eight asynchronous peripheral interrupt sources plus one external NMI line, synchronizes them, and latches or passes them according to a per-source mode. It drives the core's `IRQ` and `NMI` inputs, and exposes four registers on the core's address and data bus.

---
 rtl/irq_pkg.sv | 33 +++
 rtl/irq_ctl_sync_edge.sv | 30 +++
 rtl/irq_ctl.sv | 132 +++++++++++++
 tb/tb_irq_ctl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared constants and helpers for the 65C02 interrupt controller.
// Register offsets, mode encodings and the vector priority encoder.
package irq_pkg;

   localparam logic [1:0] REG_STATUS = 2'd0;
   localparam logic [1:0] REG_ENABLE = 2'd1;
   localparam logic [1:0] REG_MODE   = 2'd2;
   localparam logic [1:0] REG_VECTOR = 2'd3;

   localparam logic MODE_LEVEL = 1'b0;
   localparam logic MODE_EDGE  = 1'b1;

   localparam logic [7:0] VEC_NONE = 8'h80;

   // Lowest-numbered active request wins; VEC_NONE when nothing is requesting.
   function automatic logic [7:0] lowest_vec(input logic [7:0] req);
      logic [7:0] vec;
      vec = VEC_NONE;
      casez (req)
         8'b???????1: vec = 8'h00;
         8'b??????10: vec = 8'h01;
         8'b?????100: vec = 8'h02;
         8'b????1000: vec = 8'h03;
         8'b???10000: vec = 8'h04;
         8'b??100000: vec = 8'h05;
         8'b?1000000: vec = 8'h06;
         8'b10000000: vec = 8'h07;
         default:     vec = VEC_NONE;
      endcase
      return vec;
   endfunction

endpackage

// File: rtl/irq_ctl_sync_edge.sv
// Multi-stage synchronizer for one asynchronous request line, plus a
// one-flop history so the rising edge of the synchronized level is visible.
module sync_edge #(
   parameter int SYNC = 2
) (
   input  logic clk,
   input  logic RST,
   input  logic din,
   output logic lvl,
   output logic rise
);

   logic [SYNC-1:0] sync_r;
   logic            prev_r;

   // Shift the raw input through the synchronizer and remember the last level.
   always_ff @(posedge clk) begin
      if (!RST) begin
         sync_r <= {SYNC{1'b0}};
         prev_r <= 1'b0;
      end else begin
         sync_r <= {sync_r[SYNC-2:0], din};
         prev_r <= sync_r[SYNC-1];
      end
   end

   assign lvl  = sync_r[SYNC-1];
   assign rise = sync_r[SYNC-1] & ~prev_r;

endmodule

// File: rtl/irq_ctl.sv
// Interrupt controller in front of the 65C02: synchronizes eight sources and
// NMI, latches or passes them per MODE, and exposes STATUS/ENABLE/MODE/VECTOR.
module irq_ctl
   import irq_pkg::*;
#(
   parameter logic [15:0] BASE = 16'hFE00,
   parameter int          SYNC = 2
) (
   input  logic        clk,
   input  logic        RST,
   input  logic [15:0] AD,
   input  logic [7:0]  DO,
   input  logic        WE,
   input  logic [7:0]  SRC,
   input  logic        NMI_IN,
   output logic [7:0]  RD,
   output logic        RD_VLD,
   output logic        IRQ,
   output logic        NMI
);

   logic [7:0] lvl_s;
   logic [7:0] rise_s;
   logic       nmi_lvl_unused_s;
   logic       nmi_rise_s;

   logic       hit_s;
   logic       wr_s;
   logic       rd_s;
   logic [1:0] off_s;
   logic [7:0] status_clr_s;
   logic       vec_ack_s;
   logic [7:0] pend_nxt_s;
   logic [7:0] rd_mux_s;

   logic [7:0] pend_r;
   logic [7:0] enable_r;
   logic [7:0] mode_r;
   logic       nmi_r;
   logic       irq_r;
   logic [7:0] rd_r;
   logic       rd_vld_r;

   for (genvar n = 0; n < 8; n++) begin : g_src
      sync_edge #(.SYNC(SYNC)) u_sync (
         .clk  (clk),
         .RST  (RST),
         .din  (SRC[n]),
         .lvl  (lvl_s[n]),
         .rise (rise_s[n])
      );
   end

   sync_edge #(.SYNC(SYNC)) u_nmi_sync (
      .clk  (clk),
      .RST  (RST),
      .din  (NMI_IN),
      .lvl  (nmi_lvl_unused_s),
      .rise (nmi_rise_s)
   );

   assign hit_s        = (AD[15:2] == BASE[15:2]);
   assign off_s        = AD[1:0];
   assign wr_s         = hit_s & WE;
   assign rd_s         = hit_s & ~WE;
   assign status_clr_s = (wr_s && (off_s == REG_STATUS)) ? DO : 8'h00;
   assign vec_ack_s    = wr_s && (off_s == REG_VECTOR);

   // A fresh edge beats a same-cycle STATUS clear; level sources just follow
   // the synchronized input, which also drops any bit latched in edge mode.
   assign pend_nxt_s = (mode_r & (rise_s | (pend_r & ~status_clr_s)))
                     | (~mode_r & lvl_s);

   // Read data selection for the addressed register.
   always_comb begin
      rd_mux_s = 8'h00;
      case (off_s)
         REG_STATUS: rd_mux_s = pend_r;
         REG_ENABLE: rd_mux_s = enable_r;
         REG_MODE:   rd_mux_s = mode_r;
         REG_VECTOR: rd_mux_s = lowest_vec(pend_r & enable_r);
         default:    rd_mux_s = 8'h00;
      endcase
   end

   // Pending vector, NMI latch and the registered IRQ request.
   always_ff @(posedge clk) begin
      if (!RST) begin
         pend_r <= 8'h00;
         nmi_r  <= 1'b0;
         irq_r  <= 1'b0;
      end else begin
         pend_r <= pend_nxt_s;
         nmi_r  <= nmi_rise_s | (nmi_r & ~vec_ack_s);
         irq_r  <= |(pend_r & enable_r);
      end
   end

   // Software-writable ENABLE and MODE registers.
   always_ff @(posedge clk) begin
      if (!RST) begin
         enable_r <= 8'h00;
         mode_r   <= {8{MODE_LEVEL}};
      end else begin
         if (wr_s && (off_s == REG_ENABLE)) begin
            enable_r <= DO;
         end
         if (wr_s && (off_s == REG_MODE)) begin
            mode_r <= DO;
         end
      end
   end

   // Read port: one-cycle latency to line up with the core's DI sampling.
   always_ff @(posedge clk) begin
      if (!RST) begin
         rd_r     <= 8'h00;
         rd_vld_r <= 1'b0;
      end else begin
         rd_vld_r <= rd_s;
         if (rd_s) begin
            rd_r <= rd_mux_s;
         end
      end
   end

   assign RD     = rd_r;
   assign RD_VLD = rd_vld_r;
   assign IRQ    = irq_r;
   assign NMI    = nmi_r;

endmodule

// File: tb/tb_irq_ctl.sv
// Self-checking bench for irq_ctl: directed scenarios plus randomized bus and
// source traffic, all compared every cycle against a behavioural model.
module tb_irq_ctl;
   import irq_pkg::*;

   localparam logic [15:0] BASE = 16'hFE00;
   localparam int          SYNC = 2;

   logic        clk = 1'b0;
   logic        RST;
   logic [15:0] AD;
   logic [7:0]  DO;
   logic        WE;
   logic [7:0]  SRC;
   logic        NMI_IN;
   logic [7:0]  RD;
   logic        RD_VLD;
   logic        IRQ;
   logic        NMI;

   irq_ctl #(.BASE(BASE), .SYNC(SYNC)) dut (
      .clk    (clk),
      .RST    (RST),
      .AD     (AD),
      .DO     (DO),
      .WE     (WE),
      .SRC    (SRC),
      .NMI_IN (NMI_IN),
      .RD     (RD),
      .RD_VLD (RD_VLD),
      .IRQ    (IRQ),
      .NMI    (NMI)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Behavioural model state.
   logic [7:0] m_pend, m_en, m_mode, m_rd;
   logic       m_vld, m_irq, m_nmi;
   logic [8:0] m_hist[$];   // {NMI_IN, SRC} as sampled at past edges, newest first

   function automatic logic [7:0] exp_vector(input logic [7:0] req);
      int idx;
      idx = -1;
      for (int i = 7; i >= 0; i--) begin
         if (req[i]) idx = i;
      end
      return (idx < 0) ? 8'h80 : 8'(idx);
   endfunction

   task automatic model_edge();
      logic [8:0] now_lvl, prv_lvl, rise;
      logic       hit;
      logic [1:0] off;
      logic [7:0] clr, old_pend, old_en;
      if (!RST) begin
         m_pend = 8'h00; m_en = 8'h00; m_mode = 8'h00; m_rd = 8'h00;
         m_vld = 1'b0; m_irq = 1'b0; m_nmi = 1'b0;
         m_hist.delete();
         for (int i = 0; i <= SYNC; i++) m_hist.push_back(9'h000);
      end else begin
         now_lvl  = m_hist[SYNC-1];
         prv_lvl  = m_hist[SYNC];
         rise     = now_lvl & ~prv_lvl;
         hit      = (AD[15:2] == BASE[15:2]);
         off      = AD[1:0];
         old_pend = m_pend;
         old_en   = m_en;
         if (hit && !WE) begin
            m_vld = 1'b1;
            case (off)
               2'd0:    m_rd = m_pend;
               2'd1:    m_rd = m_en;
               2'd2:    m_rd = m_mode;
               default: m_rd = exp_vector(m_pend & m_en);
            endcase
         end else begin
            m_vld = 1'b0;
         end
         m_irq = |(old_pend & old_en);
         clr   = (hit && WE && off == 2'd0) ? DO : 8'h00;
         for (int i = 0; i < 8; i++) begin
            if (m_mode[i]) m_pend[i] = rise[i] | (old_pend[i] & ~clr[i]);
            else           m_pend[i] = now_lvl[i];
         end
         m_nmi = rise[8] | (m_nmi & !(hit && WE && off == 2'd3));
         if (hit && WE && off == 2'd1) m_en   = DO;
         if (hit && WE && off == 2'd2) m_mode = DO;
         m_hist.push_front({NMI_IN, SRC});
         void'(m_hist.pop_back());
      end
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
      chk("rd_vld", {7'b0, RD_VLD}, {7'b0, m_vld});
      chk("rd",     RD,             m_rd);
      chk("irq",    {7'b0, IRQ},    {7'b0, m_irq});
      chk("nmi",    {7'b0, NMI},    {7'b0, m_nmi});
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic wr(input logic [1:0] off, input logic [7:0] d);
      AD = {BASE[15:2], off}; WE = 1'b1; DO = d;
      tick();
      AD = 16'h0000; WE = 1'b0;
   endtask

   task automatic rd(input logic [1:0] off, output logic [7:0] d);
      AD = {BASE[15:2], off}; WE = 1'b0;
      tick();
      d  = RD;
      AD = 16'h0000;
   endtask

   logic [7:0] v;

   initial begin
      RST = 1'b0; WE = 1'b0; AD = 16'h0000; DO = 8'h00;
      SRC = 8'hFF; NMI_IN = 1'b1;
      idle(4);
      chk("rst_irq",    {7'b0, IRQ},    8'h00);
      chk("rst_nmi",    {7'b0, NMI},    8'h00);
      chk("rst_rd_vld", {7'b0, RD_VLD}, 8'h00);
      RST = 1'b1; SRC = 8'h00; NMI_IN = 1'b0;
      rd(REG_STATUS, v); chk("rst_status", v, 8'h00);
      rd(REG_ENABLE, v); chk("rst_enable", v, 8'h00);
      rd(REG_MODE,   v); chk("rst_mode",   v, 8'h00);
      rd(REG_VECTOR, v); chk("rst_vector", v, VEC_NONE);

      // Edge latch and clear on source 2.
      wr(REG_MODE, 8'h04); wr(REG_ENABLE, 8'h04);
      SRC = 8'h04; idle(2); SRC = 8'h00;
      tick(); chk("edge_irq_early", {7'b0, IRQ}, 8'h00);
      tick(); chk("edge_irq",       {7'b0, IRQ}, 8'h01);
      rd(REG_STATUS, v); chk("edge_status", v, 8'h04);
      rd(REG_VECTOR, v); chk("edge_vector", v, 8'h02);
      wr(REG_STATUS, 8'h04); chk("clr_irq_hold", {7'b0, IRQ}, 8'h01);
      tick();                chk("clr_irq",      {7'b0, IRQ}, 8'h00);

      // Level mode on source 0.
      wr(REG_MODE, 8'h00); wr(REG_ENABLE, 8'h01);
      SRC = 8'h01; idle(4); chk("lvl_irq", {7'b0, IRQ}, 8'h01);
      wr(REG_STATUS, 8'hFF); tick(); chk("lvl_irq_noclr", {7'b0, IRQ}, 8'h01);
      SRC = 8'h00; idle(3); chk("lvl_irq_tail", {7'b0, IRQ}, 8'h01);
      tick();               chk("lvl_irq_low",  {7'b0, IRQ}, 8'h00);

      // Priority and masking.
      wr(REG_MODE, 8'hFF); wr(REG_ENABLE, 8'hA0);
      SRC = 8'hA2; idle(2); SRC = 8'h00; idle(3);
      rd(REG_VECTOR, v); chk("prio_vec5",   v, 8'h05);
      rd(REG_STATUS, v); chk("prio_status", v, 8'hA2);
      wr(REG_STATUS, 8'h20);
      rd(REG_VECTOR, v); chk("prio_vec7",   v, 8'h07);
      wr(REG_STATUS, 8'h80);
      rd(REG_VECTOR, v); chk("prio_none",   v, VEC_NONE);
      chk("prio_irq_low", {7'b0, IRQ}, 8'h00);

      // Set/clear collisions.
      wr(REG_STATUS, 8'hFF);
      SRC = 8'h08; idle(2); wr(REG_STATUS, 8'h08); SRC = 8'h00;
      rd(REG_STATUS, v); chk("coll_status", v, 8'h08);
      NMI_IN = 1'b1; idle(2); wr(REG_VECTOR, 8'h00); NMI_IN = 1'b0;
      chk("coll_nmi", {7'b0, NMI}, 8'h01);

      // NMI pulse, acknowledge, re-arm.
      wr(REG_VECTOR, 8'h00); chk("nmi_ack", {7'b0, NMI}, 8'h00);
      NMI_IN = 1'b1; idle(2); chk("nmi_early", {7'b0, NMI}, 8'h00);
      tick();                 chk("nmi_set",   {7'b0, NMI}, 8'h01);
      NMI_IN = 1'b0; idle(5); chk("nmi_sticky", {7'b0, NMI}, 8'h01);
      wr(REG_VECTOR, 8'h00);  chk("nmi_ack2",  {7'b0, NMI}, 8'h00);
      NMI_IN = 1'b1; idle(3); NMI_IN = 1'b0;
      chk("nmi_again", {7'b0, NMI}, 8'h01);

      // Randomized traffic, including occasional resets.
      for (int c = 0; c < 3000; c++) begin
         RST = ($urandom_range(0, 99) != 0);
         WE  = ($urandom_range(0, 9) < 4);
         AD  = ($urandom_range(0, 3) != 0) ? {BASE[15:2], 2'($urandom)} : 16'($urandom);
         DO  = 8'($urandom);
         if ($urandom_range(0, 3) == 0) SRC = 8'($urandom);
         if ($urandom_range(0, 7) == 0) NMI_IN = ~NMI_IN;
         tick();
      end
      RST = 1'b1; WE = 1'b0; AD = 16'h0000;
      idle(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
